mac_tx_ctrl: RTL and testbench

Transmit-side MAC controller. It pulls frame bytes from the first-word-fall-through TX FIFO and drives the byte-wide MII/GMII transmit interface. Each frame is sent as preamble, SFD, data, zero pad to minimum length, then a generated FCS. After the frame it enforces the inter-frame gap and supplies per-frame RMON statistics.

---
 rtl/mac_tx_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mac_tx_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_ctrl.sv
// Transmit MAC controller: FIFO -> MII/GMII byte stream with preamble, pad, FCS, IFG and RMON.
// Define MAC_TX_PAUSE_EN to build the pause-quanta counter and PAUSE state.
module mac_tx_ctrl #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_DATA_LEN = 60,
   parameter int PAUSE_SLOT   = 64
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [7:0]  Fifo_data,
   input  logic        Fifo_data_en,
   input  logic        Fifo_data_end,
   output logic        Fifo_rd,
   output logic [7:0]  MTxD,
   output logic        MTxEn,
   output logic        MTxErr,
   input  logic [5:0]  TX_IFG_SET,
   input  logic [15:0] pause_quanta,
   input  logic        pause_quanta_val,
   output logic [15:0] Tx_pkt_length_rmon,
   output logic        Tx_apply_rmon,
   output logic        Tx_pkt_err_rmon
);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG
`ifdef MAC_TX_PAUSE_EN
      , PAUSE
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  ph_cnt;
   logic [15:0] byte_cnt, cnt_inc;
   logic [31:0] crc, fcs;
   logic        abort;
   logic        pause_pend;
   logic [5:0]  ifg_len;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
   assign fcs     = ~crc;
   assign ifg_len = (TX_IFG_SET < 6'd12) ? 6'd12 : TX_IFG_SET;

`ifdef MAC_TX_PAUSE_EN
   logic [15:0] quanta;
   logic [15:0] presc;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         quanta <= '0;
         presc  <= '0;
      end else if (pause_quanta_val) begin
         quanta <= pause_quanta;
         presc  <= '0;
      end else if (quanta != 16'd0) begin
         if (presc == 16'(PAUSE_SLOT - 1)) begin
            presc  <= '0;
            quanta <= quanta - 16'd1;
         end else begin
            presc <= presc + 16'd1;
         end
      end
   end

   assign pause_pend = (quanta != 16'd0);
`else
   wire unused_pause = ^{pause_quanta, pause_quanta_val};
   assign pause_pend = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      Fifo_rd   = 1'b0;
      unique case (state)
         IDLE: begin
`ifdef MAC_TX_PAUSE_EN
            if (pause_pend) state_nxt = PAUSE;
            else
`endif
            if (Fifo_data_en && !pause_pend) state_nxt = PREAMBLE;
         end
         PREAMBLE: if (ph_cnt == 8'(PREAMBLE_LEN - 1)) state_nxt = SFD;
         SFD:      state_nxt = DATA;
         DATA: begin
            Fifo_rd = 1'b1;
            if (!Fifo_data_en)
               state_nxt = IFG;
            else if (Fifo_data_end)
               state_nxt = (cnt_inc < 16'(MIN_DATA_LEN)) ? PAD : FCS;
         end
         PAD:      if (cnt_inc >= 16'(MIN_DATA_LEN)) state_nxt = FCS;
         FCS:      if (ph_cnt == 8'd3) state_nxt = IFG;
         // IFG state lasts one clock short of the gap; the IDLE clock completes it
         IFG: begin
            if (ph_cnt == 8'(ifg_len) - 8'd2) begin
`ifdef MAC_TX_PAUSE_EN
               state_nxt = pause_pend ? PAUSE : IDLE;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef MAC_TX_PAUSE_EN
         PAUSE:    if (!pause_pend) state_nxt = IDLE;
`endif
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state              <= IDLE;
         ph_cnt             <= '0;
         byte_cnt           <= '0;
         crc                <= '0;
         abort              <= 1'b0;
         MTxD               <= '0;
         MTxEn              <= 1'b0;
         MTxErr             <= 1'b0;
         Tx_pkt_length_rmon <= '0;
         Tx_apply_rmon      <= 1'b0;
         Tx_pkt_err_rmon    <= 1'b0;
      end else begin
         state         <= state_nxt;
         ph_cnt        <= (state_nxt != state) ? 8'd0 : ph_cnt + 8'd1;
         MTxD          <= 8'h00;
         MTxEn         <= 1'b0;
         MTxErr        <= 1'b0;
         Tx_apply_rmon <= 1'b0;
         case (state)
            PREAMBLE: begin
               MTxD  <= 8'h55;
               MTxEn <= 1'b1;
            end
            SFD: begin
               MTxD     <= 8'hD5;
               MTxEn    <= 1'b1;
               crc      <= 32'hFFFF_FFFF;
               byte_cnt <= '0;
               abort    <= 1'b0;
            end
            DATA: begin
               MTxEn <= 1'b1;
               if (Fifo_data_en) begin
                  MTxD     <= Fifo_data;
                  crc      <= crc_byte(crc, Fifo_data);
                  byte_cnt <= cnt_inc;
               end else begin
                  MTxErr <= 1'b1;
                  abort  <= 1'b1;
               end
            end
            PAD: begin
               MTxEn    <= 1'b1;
               crc      <= crc_byte(crc, 8'h00);
               byte_cnt <= cnt_inc;
            end
            FCS: begin
               MTxEn <= 1'b1;
               MTxD  <= fcs[ph_cnt[1:0]*8 +: 8];
            end
            IFG: begin
               if (ph_cnt == 8'd0) begin
                  Tx_apply_rmon      <= 1'b1;
                  Tx_pkt_err_rmon    <= abort;
                  Tx_pkt_length_rmon <= abort ? byte_cnt :
                                        (byte_cnt > 16'hFFFB) ? 16'hFFFF : byte_cnt + 16'd4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx_ctrl.sv
// Scoreboard bench for mac_tx_ctrl: frame-level model queues expected line bytes and RMON records.
module tb_mac_tx_ctrl;
   localparam int MIN_LEN = 60;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [7:0]  Fifo_data = '0;
   logic        Fifo_data_en = 1'b0;
   logic        Fifo_data_end = 1'b0;
   logic        Fifo_rd;
   logic [7:0]  MTxD;
   logic        MTxEn, MTxErr;
   logic [5:0]  TX_IFG_SET;
   logic [15:0] pause_quanta;
   logic        pause_quanta_val;
   logic [15:0] Tx_pkt_length_rmon;
   logic        Tx_apply_rmon, Tx_pkt_err_rmon;

   mac_tx_ctrl dut (
      .Clk(Clk), .Reset(Reset), .Fifo_data(Fifo_data), .Fifo_data_en(Fifo_data_en),
      .Fifo_data_end(Fifo_data_end), .Fifo_rd(Fifo_rd), .MTxD(MTxD), .MTxEn(MTxEn),
      .MTxErr(MTxErr), .TX_IFG_SET(TX_IFG_SET), .pause_quanta(pause_quanta),
      .pause_quanta_val(pause_quanta_val), .Tx_pkt_length_rmon(Tx_pkt_length_rmon),
      .Tx_apply_rmon(Tx_apply_rmon), .Tx_pkt_err_rmon(Tx_pkt_err_rmon)
   );

   always #5 Clk = ~Clk;

   typedef struct { logic [7:0] d; logic e; } fent_t;
   typedef struct { logic [7:0] d; logic err; } ob_t;
   typedef struct { logic [15:0] len; logic err; } rm_t;

   fent_t fq[$];
   ob_t   exp_q[$];
   rm_t   rmon_q[$];
   int    gap_q[$];
   int    n_cmp = 0, n_bad = 0;
   bit    mon_en = 0;
   int    cyc = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // FWFT FIFO model: pop decided from the values the DUT sees at the coming edge
   always begin
      bit wp;
      @(negedge Clk);
      wp = Fifo_rd && Fifo_data_en;
      @(posedge Clk);
      #1;
      if (wp && fq.size() != 0) void'(fq.pop_front());
      #1;
      if (fq.size() != 0) begin
         Fifo_data_en = 1'b1; Fifo_data = fq[0].d; Fifo_data_end = fq[0].e;
      end else begin
         Fifo_data_en = 1'b0; Fifo_data = 8'h00; Fifo_data_end = 1'b0;
      end
   end

   // Monitor: line bytes, RMON pulses, inter-frame gaps, FCS residue
   always @(negedge Clk) begin
      static bit prev_en = 0, have_fall = 0, ferr = 0;
      static int idle = 0, k = 0;
      static logic [31:0] rcrc = 32'hFFFF_FFFF;
      ob_t e;
      rm_t r;
      if (!mon_en || Reset) begin
         prev_en = 0; have_fall = 0; idle = 0; k = 0;
      end else begin
         if (MTxEn) begin
            if (!prev_en) begin
               if (have_fall && gap_q.size() != 0) chk("ifg_gap", idle, gap_q.pop_front());
               k = 0; ferr = 0; rcrc = 32'hFFFF_FFFF;
            end
            if (exp_q.size() == 0) fail("unexpected_tx_byte");
            else begin
               e = exp_q.pop_front();
               chk("tx_byte", {MTxErr, MTxD}, {e.err, e.d});
            end
            if (MTxErr) ferr = 1;
            if (k >= 8) rcrc = crc_upd(rcrc, MTxD);
            k++;
            idle = 0;
         end else begin
            if (prev_en) begin
               have_fall = 1;
               if (!ferr) chk("fcs_residue", rcrc, 32'hDEBB_20E3);
            end
            if (MTxErr) fail("err_without_en");
            idle++;
         end
         if (Tx_apply_rmon) begin
            if (rmon_q.size() == 0) fail("unexpected_rmon");
            else begin
               r = rmon_q.pop_front();
               chk("rmon_err", Tx_pkt_err_rmon, r.err);
               if (!r.err) chk("rmon_len", Tx_pkt_length_rmon, r.len);
            end
         end
         prev_en = MTxEn;
      end
   end

   // Frame-level reference: what the wire should carry for one FIFO frame
   task automatic send_frame(input int len, input int under_at);
      logic [31:0] c;
      logic [7:0]  d;
      int n, padn;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, 1'b0});
      exp_q.push_back('{8'hD5, 1'b0});
      n = (under_at > 0) ? under_at : len;
      for (int i = 0; i < n; i++) begin
         d = 8'($urandom);
         fq.push_back('{d, (under_at == 0) && (i == len - 1)});
         exp_q.push_back('{d, 1'b0});
         c = crc_upd(c, d);
      end
      if (under_at > 0) begin
         exp_q.push_back('{8'h00, 1'b1});
         rmon_q.push_back('{16'(under_at), 1'b1});
      end else begin
         padn = (len < MIN_LEN) ? MIN_LEN - len : 0;
         for (int i = 0; i < padn; i++) begin
            exp_q.push_back('{8'h00, 1'b0});
            c = crc_upd(c, 8'h00);
         end
         c = ~c;
         for (int i = 0; i < 4; i++) exp_q.push_back('{c[i*8 +: 8], 1'b0});
         rmon_q.push_back('{16'(len + padn + 4), 1'b0});
      end
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge Clk);
         if (exp_q.size() == 0 && rmon_q.size() == 0 && !MTxEn && fq.size() == 0) break;
      end
      if (i == 3000) begin
         fail("wait_idle_timeout");
         exp_q.delete(); rmon_q.delete(); fq.delete();
      end
      gap_q.delete();
      repeat (2) @(negedge Clk);
   endtask

   task automatic wait_rise();
      for (int i = 0; i < 400 && !MTxEn; i++) @(negedge Clk);
      if (!MTxEn) fail("rise_timeout");
   endtask

   task automatic pair(input int la, input int lb, input int ifg);
      TX_IFG_SET = 6'(ifg);
      send_frame(la, 0);
      send_frame(lb, 0);
      wait_rise();
      gap_q.push_back((ifg < 12) ? 12 : ifg);
      wait_idle();
   endtask

   initial begin
      int len, kind, t0;
      #900000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int len, kind, t0;
      Reset = 1'b1; TX_IFG_SET = 6'd12; pause_quanta = '0; pause_quanta_val = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_MTxEn", MTxEn, 0);
      chk("rst_MTxD", MTxD, 0);
      chk("rst_MTxErr", MTxErr, 0);
      chk("rst_Fifo_rd", Fifo_rd, 0);
      chk("rst_apply", Tx_apply_rmon, 0);
      chk("rst_len", Tx_pkt_length_rmon, 0);
      chk("rst_err", Tx_pkt_err_rmon, 0);
      Reset = 1'b0;
      mon_en = 1;
      @(negedge Clk);

      send_frame(64, 0); wait_idle();
      send_frame(10, 0); wait_idle();
      pair(20, 30, 5);
      pair(15, 70, 20);
      send_frame(50, 30); wait_idle();

      // reset while the FCS of a padded 20-byte frame is on the wire
      mon_en = 0;
      send_frame(20, 0);
      wait_rise();
      repeat (69) @(negedge Clk);
      chk("mid_fcs_en", MTxEn, 1);
      Reset = 1'b1;
      @(negedge Clk);
      chk("rst_mid_MTxEn", MTxEn, 0);
      chk("rst_mid_MTxD", MTxD, 0);
      chk("rst_mid_Fifo_rd", Fifo_rd, 0);
      @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         chk("post_rst_apply", Tx_apply_rmon, 0);
         chk("post_rst_en", MTxEn, 0);
      end
      exp_q.delete(); rmon_q.delete(); gap_q.delete();
      mon_en = 1;
      send_frame(30, 0); wait_idle();

`ifdef MAC_TX_PAUSE_EN
      TX_IFG_SET = 6'd12;
      send_frame(40, 0);
      wait_rise();
      repeat (20) @(negedge Clk);
      pause_quanta = 16'd3; pause_quanta_val = 1'b1; t0 = cyc;
      @(negedge Clk);
      pause_quanta_val = 1'b0;
      send_frame(40, 0);
      for (int i = 0; i < 600 && MTxEn; i++) @(negedge Clk);
      for (int i = 0; i < 600 && !MTxEn; i++) @(negedge Clk);
      chk("pause_hold", (cyc - t0) >= 192, 1);
      wait_idle();
      pause_quanta = 16'd100; pause_quanta_val = 1'b1;
      @(negedge Clk);
      pause_quanta_val = 1'b0;
      send_frame(20, 0);
      repeat (50) @(negedge Clk);
      chk("pause_block", MTxEn, 0);
      pause_quanta = 16'd0; pause_quanta_val = 1'b1;
      @(negedge Clk);
      pause_quanta_val = 1'b0;
      wait_idle();
`endif

      for (int f = 0; f < 30; f++) begin
         TX_IFG_SET = 6'($urandom_range(0, 63));
         len  = $urandom_range(1, 120);
         kind = $urandom_range(0, 4);
         if (kind == 0 && len > 1) begin
            send_frame(len, $urandom_range(1, len - 1));
            wait_idle();
         end else if (kind == 1) begin
            pair(len, $urandom_range(1, 120), int'(TX_IFG_SET));
         end else begin
            send_frame(len, 0);
            wait_idle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
